// File: rtl/cmd_response_receiver_pkg.sv
// Shared definitions for the CMD-line response receive path: FSM state
// encoding, frame lengths and the CRC7 constants used by both the receiver
// and the transmit-side CRC generator.
package cmd_response_receiver_pkg;

  localparam int RSP_SHORT_LEN = 48;   // R1/R3/R6/R7 frame length
  localparam int RSP_LONG_LEN  = 136;  // R2 frame length
  localparam int RSP_NCR_MAX   = 64;   // start-bit wait limit in sd_clock cycles
  localparam int RSP_CNT_W     = 8;    // bit / timeout counter width

  localparam logic [6:0] CRC7_POLY    = 7'h09;  // x^7 + x^3 + 1
  localparam int         R2_CRC_SKIP  = 8;      // start, transmission, 6 reserved bits
  localparam int         CRC_TAIL_LEN = 8;      // CRC7 field plus end bit

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_RECEIVE    = 3'd2,
    ST_CHECK      = 3'd3,
    ST_DONE       = 3'd4
  } rx_state_t;

endpackage

// File: rtl/cmd_response_receiver_crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), MSB-first, register initialised to zero.
// Shared between the response receiver and the command transmit path.
module crc7_serial
  import cmd_response_receiver_pkg::*;
(
  input  logic       sd_clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_bit,
  output logic [6:0] crc
);

  logic feedback;

  assign feedback = data_bit ^ crc[6];

  // Galois-form LFSR update; clear takes priority over a data bit
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[5:0], 1'b0} ^ ({7{feedback}} & CRC7_POLY);
    end
  end

endmodule

// File: rtl/cmd_response_receiver.sv
// Host-side CMD response receiver: waits for a start bit after arm,
// deserialises a 48- or 136-bit response MSB-first, checks CRC7 and the end
// bit, and hands frame plus error flags to cmd_controller via strobe/ack.
module cmd_response_receiver
  import cmd_response_receiver_pkg::*;
#(
  parameter int SHORT_LEN = RSP_SHORT_LEN,
  parameter int LONG_LEN  = RSP_LONG_LEN,
  parameter int NCR_MAX   = RSP_NCR_MAX,
  parameter int CNT_W     = RSP_CNT_W
) (
  input  logic                sd_clock,
  input  logic                reset,
  input  logic                arm,
  input  logic                long_response,
  input  logic                check_crc,
  input  logic                cmd_pin,
  input  logic                ack_in,
  output logic                strobe_out,
  output logic [LONG_LEN-1:0] response,
  output logic                crc_error,
  output logic                end_error,
  output logic                timeout_error,
  output logic                busy
);

  localparam logic [CNT_W-1:0] SHORT_LEN_C = CNT_W'(SHORT_LEN);
  localparam logic [CNT_W-1:0] LONG_LEN_C  = CNT_W'(LONG_LEN);
  localparam logic [CNT_W-1:0] NCR_MAX_C   = CNT_W'(NCR_MAX);
  localparam logic [CNT_W-1:0] SKIP_C      = CNT_W'(R2_CRC_SKIP);
  localparam logic [CNT_W-1:0] TAIL_C      = CNT_W'(CRC_TAIL_LEN);

  rx_state_t           state;
  logic                long_q;
  logic                check_crc_q;
  logic [CNT_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]    tmo_cnt;
  logic [LONG_LEN-1:0] shift_reg;

  logic [CNT_W-1:0]    frame_len;
  logic [CNT_W-1:0]    crc_skip;
  logic [CNT_W-1:0]    bit_idx;
  logic                shifting;
  logic                crc_clear;
  logic                crc_en;
  logic [6:0]          crc_calc;

  // Frame geometry for the latched response type. The start bit is frame
  // bit index 0 and is sampled in WAIT_START, later bits in RECEIVE.
  assign frame_len = long_q ? LONG_LEN_C : SHORT_LEN_C;
  assign crc_skip  = long_q ? SKIP_C : '0;
  assign bit_idx   = (state == ST_WAIT_START) ? '0 : bit_cnt;
  assign shifting  = ((state == ST_WAIT_START) && !cmd_pin) ||
                     ((state == ST_RECEIVE) && (bit_cnt != frame_len));
  // CRC covers everything after the skipped header up to the CRC field
  assign crc_en    = shifting && (bit_idx >= crc_skip) &&
                     (bit_idx < (frame_len - TAIL_C));
  assign crc_clear = (state == ST_IDLE) && arm;

  crc7_serial u_crc7 (
    .sd_clock (sd_clock),
    .reset    (reset),
    .clear    (crc_clear),
    .enable   (crc_en),
    .data_bit (cmd_pin),
    .crc      (crc_calc)
  );

  // Receive FSM with registered handshake, result and status outputs
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      long_q        <= 1'b0;
      check_crc_q   <= 1'b0;
      bit_cnt       <= '0;
      tmo_cnt       <= '0;
      shift_reg     <= '0;
      strobe_out    <= 1'b0;
      response      <= '0;
      crc_error     <= 1'b0;
      end_error     <= 1'b0;
      timeout_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            long_q        <= long_response;
            check_crc_q   <= check_crc;
            tmo_cnt       <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            crc_error     <= 1'b0;
            end_error     <= 1'b0;
            timeout_error <= 1'b0;
            busy          <= 1'b1;
            state         <= ST_WAIT_START;
          end
        end
        ST_WAIT_START: begin
          // A start bit wins over an expiring timeout on the same cycle
          if (!cmd_pin) begin
            shift_reg <= {shift_reg[LONG_LEN-2:0], cmd_pin};
            bit_cnt   <= CNT_W'(1);
            state     <= ST_RECEIVE;
          end else if (tmo_cnt == NCR_MAX_C) begin
            timeout_error <= 1'b1;
            response      <= '0;
            strobe_out    <= 1'b1;
            state         <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        ST_RECEIVE: begin
          if (bit_cnt == frame_len) begin
            state <= ST_CHECK;
          end else begin
            shift_reg <= {shift_reg[LONG_LEN-2:0], cmd_pin};
            bit_cnt   <= bit_cnt + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          crc_error  <= check_crc_q && (crc_calc != shift_reg[7:1]);
          end_error  <= !shift_reg[0];
          response   <= shift_reg;
          strobe_out <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          if (ack_in) begin
            strobe_out <= 1'b0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          strobe_out <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_response_receiver.sv
// Directed bench for cmd_response_receiver: short/long frames, CRC and end-bit
// faults, timeout and its start-bit boundary, reset mid-frame, delayed ack.
module tb_cmd_response_receiver;

  logic         sd_clock;
  logic         reset;
  logic         arm;
  logic         long_response;
  logic         check_crc;
  logic         cmd_pin;
  logic         ack_in;
  logic         strobe_out;
  logic [135:0] response;
  logic         crc_error;
  logic         end_error;
  logic         timeout_error;
  logic         busy;

  int checks = 0;
  int errors = 0;

  cmd_response_receiver dut (
    .sd_clock      (sd_clock),
    .reset         (reset),
    .arm           (arm),
    .long_response (long_response),
    .check_crc     (check_crc),
    .cmd_pin       (cmd_pin),
    .ack_in        (ack_in),
    .strobe_out    (strobe_out),
    .response      (response),
    .crc_error     (crc_error),
    .end_error     (end_error),
    .timeout_error (timeout_error),
    .busy          (busy)
  );

  initial sd_clock = 1'b0;
  always #5 sd_clock = ~sd_clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge sd_clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC7 over frame bits hi..lo, MSB first
  function automatic logic [6:0] crc7_ref(input logic [135:0] f, input int hi, input int lo);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = hi; i >= lo; i--) begin
      fb = f[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // Arm, wait idle cycles, drive the frame and check the exact strobe latency
  task automatic run_frame(input logic [135:0] f, input int len, input logic lng,
                           input logic crc_on, input int idle, input bit arm_mid,
                           input string tag);
    long_response = lng;
    check_crc     = crc_on;
    arm           = 1'b1;
    tick();
    arm = 1'b0;
    chk1({tag, "_busy"}, busy, 1'b1);
    repeat (idle) tick();
    for (int i = len - 1; i >= 0; i--) begin
      cmd_pin = f[i];
      arm     = arm_mid && (i == len - 21);
      tick();
    end
    arm     = 1'b0;
    cmd_pin = 1'b1;
    tick();
    chk1({tag, "_strobe_early"}, strobe_out, 1'b0);
    tick();
    chk1({tag, "_strobe"}, strobe_out, 1'b1);
  endtask

  // Hold off ack for delay cycles, verifying the result stays put
  task automatic do_ack(input int delay, input logic [135:0] exp_resp, input string tag);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk1({tag, "_strobe_held"}, strobe_out, 1'b1);
      chkw({tag, "_resp_held"}, response, exp_resp);
    end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk1({tag, "_strobe_off"}, strobe_out, 1'b0);
    chk1({tag, "_idle"}, busy, 1'b0);
    chkw({tag, "_resp_after_ack"}, response, exp_resp);
  endtask

  task automatic chk_flags(input string tag, input logic ce, input logic ee, input logic te);
    chk1({tag, "_crc_error"}, crc_error, ce);
    chk1({tag, "_end_error"}, end_error, ee);
    chk1({tag, "_timeout_error"}, timeout_error, te);
  endtask

  logic [135:0] f_ok, f_badcrc, f_badend, f_long, f_zero;

  initial begin
    reset         = 1'b0;
    arm           = 1'b0;
    long_response = 1'b0;
    check_crc     = 1'b0;
    cmd_pin       = 1'b1;
    ack_in        = 1'b0;

    f_ok     = 136'h110000090067;
    f_badcrc = 136'h110000090065;
    f_badend = 136'h110000090066;
    f_zero   = '0;
    f_long   = {8'h3F, 120'h035344535531364780123456780132, 7'h00, 1'b1};
    f_long[7:1] = crc7_ref(f_long, 127, 8);

    // Reset state
    tick();
    tick();
    chk1("rst_strobe", strobe_out, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chkw("rst_response", response, f_zero);
    chk_flags("rst", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();

    // Short R1, valid; ack delayed 5 cycles
    run_frame(f_ok, 48, 1'b0, 1'b1, 10, 1'b0, "r1");
    chkw("r1_response", response, f_ok);
    chk_flags("r1", 1'b0, 1'b0, 1'b0);
    do_ack(5, f_ok, "r1");

    // CRC fault, checked then unchecked
    run_frame(f_badcrc, 48, 1'b0, 1'b1, 3, 1'b0, "crcbad");
    chkw("crcbad_response", response, f_badcrc);
    chk_flags("crcbad", 1'b1, 1'b0, 1'b0);
    do_ack(0, f_badcrc, "crcbad");
    run_frame(f_badcrc, 48, 1'b0, 1'b0, 3, 1'b0, "crcoff");
    chk_flags("crcoff", 1'b0, 1'b0, 1'b0);
    do_ack(0, f_badcrc, "crcoff");

    // End-bit fault (CRC field still correct)
    run_frame(f_badend, 48, 1'b0, 1'b1, 2, 1'b0, "endbad");
    chk_flags("endbad", 1'b0, 1'b1, 1'b0);
    do_ack(0, f_badend, "endbad");

    // Timeout: no start bit, strobe NCR_MAX+1 cycles after WAIT_START entry
    long_response = 1'b0;
    check_crc     = 1'b1;
    arm           = 1'b1;
    tick();
    arm = 1'b0;
    repeat (64) tick();
    chk1("tmo_strobe_early", strobe_out, 1'b0);
    tick();
    chk1("tmo_strobe", strobe_out, 1'b1);
    chkw("tmo_response", response, f_zero);
    chk_flags("tmo", 1'b0, 1'b0, 1'b1);
    do_ack(0, f_zero, "tmo");

    // Start bit on the cycle the timeout counter sits at NCR_MAX: start wins
    run_frame(f_ok, 48, 1'b0, 1'b1, 64, 1'b0, "tmoedge");
    chkw("tmoedge_response", response, f_ok);
    chk_flags("tmoedge", 1'b0, 1'b0, 1'b0);
    do_ack(0, f_ok, "tmoedge");

    // Long R2 with valid CRC over bits 127..8
    run_frame(f_long, 136, 1'b1, 1'b1, 4, 1'b0, "r2");
    chkw("r2_response", response, f_long);
    chk_flags("r2", 1'b0, 1'b0, 1'b0);
    do_ack(1, f_long, "r2");

    // Arm pulse mid-RECEIVE is ignored: same result, same latency
    run_frame(f_ok, 48, 1'b0, 1'b1, 2, 1'b1, "armmid");
    chkw("armmid_response", response, f_ok);
    chk_flags("armmid", 1'b0, 1'b0, 1'b0);
    do_ack(0, f_ok, "armmid");

    // Reset asserted at bit 20 of a frame: everything clears at once
    long_response = 1'b0;
    check_crc     = 1'b1;
    arm           = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 47; i >= 28; i--) begin
      cmd_pin = f_ok[i];
      tick();
    end
    reset = 1'b0;
    #2;
    chk1("midrst_strobe", strobe_out, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chkw("midrst_response", response, f_zero);
    chk_flags("midrst", 1'b0, 1'b0, 1'b0);
    cmd_pin = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk1("midrst_hold_idle", busy, 1'b0);

    // A fresh arm after reset receives correctly
    run_frame(f_ok, 48, 1'b0, 1'b1, 5, 1'b0, "postrst");
    chkw("postrst_response", response, f_ok);
    chk_flags("postrst", 1'b0, 1'b0, 1'b0);
    do_ack(0, f_ok, "postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_response_receiver.md
Name: cmd_response_receiver

Overview:
Host-side CMD-line response receiver that sits between the cmd pin and cmd_controller, alongside cmd_phys on the receive path. When armed, it waits for a response start bit and deserializes a 48-bit short or 136-bit long (R2) response MSB-first. It then checks the CRC7 and the end bit. The received frame and error flags go to cmd_controller over the codebase strobe/ack handshake.

Parameters:
SHORT_LEN, 48, frame bits in a short response (R1/R3/R6/R7)
LONG_LEN, 136, frame bits in a long response (R2)
NCR_MAX, 64, sd_clock cycles allowed between arm and start bit before timeout
CNT_W, 8, width of the bit and timeout counters

Ports:
sd_clock  input  1  single clock; cmd_pin sampled on rising edge
reset  input  1  asynchronous, active-low reset
arm  input  1  one-cycle pulse: start waiting for a response (honoured only in IDLE)
long_response  input  1  latched on arm; 1 = expect LONG_LEN bits
check_crc  input  1  latched on arm; 0 = skip CRC check (R3)
cmd_pin  input  1  serial CMD line from pad (idles high)
ack_in  input  1  consumer acknowledges the result
strobe_out  output  1  result valid; held until ack_in
response  output  136  received frame, right-justified; short frame in [47:0], [135:48]=0
crc_error  output  1  CRC7 mismatch (valid with strobe_out)
end_error  output  1  last bit was not 1 (valid with strobe_out)
timeout_error  output  1  no start bit within NCR_MAX cycles (valid with strobe_out)
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs, counters, shift register and CRC register clear to 0. This also applies when reset is asserted mid-frame; no partial result is ever strobed.
- States: IDLE, WAIT_START, RECEIVE, CHECK, DONE.
- IDLE:
  - arm=1 latches long_response and check_crc, clears the timeout counter, CRC register and error flags, and moves to WAIT_START next cycle.
  - arm=0 holds IDLE.
- WAIT_START:
  - Sampled cmd_pin=0 is the start bit. Shift it in, set bit_cnt=1, go to RECEIVE.
  - Otherwise increment the timeout counter. When it reaches NCR_MAX, set timeout_error=1, response=0, and go to DONE.
  - A start bit on the same cycle the counter reaches NCR_MAX counts as a start bit; the start bit wins.
- RECEIVE:
  - Each cycle, shift cmd_pin into the LSB of the shift register and increment bit_cnt.
  - When bit_cnt reaches LEN (SHORT_LEN or LONG_LEN), go to CHECK.
- CRC7, polynomial x^7+x^3+1, register init 0, fed serially while receiving:
  - Short frame: covers frame bits 47..8 (start, transmission, index, argument).
  - Long frame: covers frame bits 127..8; the first 8 bits (start, transmission, 6 reserved) are excluded.
  - Frame bits 7..1 are compared with the register. Frame bit 0 is the end bit.
- CHECK (one cycle):
  - crc_error = check_crc & (computed != received).
  - end_error = (bit0 != 1).
  - Load response. Go to DONE.
- DONE:
  - strobe_out=1 with stable response and flags.
  - ack_in=1 sampled in DONE: next cycle strobe_out=0, go to IDLE.
  - ack_in in any other state is ignored.
  - response and the flags hold their values after ack until the next arm.
- Latency:
  - Start bit sampled at cycle 0 → strobe_out high at cycle LEN+1 (49 short, 137 long).
  - Timeout: strobe_out high NCR_MAX+1 cycles after the WAIT_START entry.
- An arm pulse outside IDLE is ignored and causes no restart.
- The transmission bit value (frame bit 46 / 134) is passed through in response; it is not checked here. Index checking belongs to cmd_controller.

Decomposition:
- Shared package/include (definitionsCMDcontroller): state encodings, SHORT_LEN/LONG_LEN, CRC7 polynomial constant 7'h09, R2 CRC-skip length 8.
- One sub-module: crc7_serial. Inputs: sd_clock, reset, clear, enable, data_bit. Output: crc[6:0]. cmd_phys transmit-side CRC generation reuses it.

Test Plan:
- Short R1: arm with long_response=0, check_crc=1; 10 idle-high cycles, then drive frame 48'h1100000900_67 → strobe_out at cycle 49 after the start bit; response=48'h110000090067; crc_error=0, end_error=0, timeout_error=0; ack_in → IDLE, busy=0.
- CRC fault: same stimulus with the last byte 8'h65 → crc_error=1, end_error=0; rerun with check_crc=0 → crc_error=0.
- End-bit fault: frame 48'h1100000900_66 → end_error=1, crc_error=0.
- Timeout: arm, hold cmd_pin=1 → strobe_out at cycle NCR_MAX+1 (65); timeout_error=1, response=0. Separately, start bit on cycle 64 → a normal receive, no timeout.
- Long R2: arm with long_response=1; send 136-bit frame 8'h3F, 120-bit CID payload, valid CRC7, end bit 1 → strobe at cycle 137; response[135:0] matches; crc_error=0.
- Reset mid-frame / handshake:
  - Drop reset at bit 20 → all outputs 0 at once, state IDLE; a new arm then receives correctly.
  - Delay ack_in 5 cycles → response stable and strobe_out held throughout.
  - arm during RECEIVE → ignored.
